serial_match_ctrl: RTL and testbench

Streaming controller that sequences a serial pattern detector. It accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per clock, into a detector history register. It compares that history against a run-time programmable pattern and reports every (overlapping) match as a one-cycle pulse plus a running count. It sits between a word-wide producer and the team's serial pattern-detection logic, replacing hard-wired FSM patterns with a configurable one.

---
 rtl/serial_match_ctrl.sv | 162 ++++++++++++++++
 tb/tb_serial_match_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_match_ctrl.sv
// serial_match_ctrl
//   Accepts WORD_W-bit words over a valid/ready handshake and shifts each one
//   MSB-first, one bit per clock, into a PAT_W-bit history register. The low
//   cfg_len bits of that history are compared with a programmable pattern.
//   Every match, including overlapping matches, produces a registered
//   one-cycle pulse.
//   Optional feature macro: MATCH_COUNT_EN. When it is defined, a saturating
//   CNT_W-bit match counter is built. When it is not defined, match_count is
//   tied to zero.
module serial_match_ctrl #(
  parameter  int WORD_W = 8,
  parameter  int PAT_W  = 6,
  parameter  int CNT_W  = 8,
  localparam int LEN_W  = $clog2(PAT_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_clear,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              state
);

  localparam int BC_W   = $clog2(WORD_W);
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [BC_W-1:0]   r_bitcnt;
  logic [WORD_W-1:0] r_shreg;
  logic [PAT_W-1:0]  r_hist;
  logic [FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]  r_pat;
  logic [LEN_W-1:0]  r_len;
  logic              r_pulse;

  logic              w_shift;
  logic              w_last;
  logic              w_ready;
  logic              w_accept;
  logic              w_bit;
  logic [PAT_W-1:0]  w_hist_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [PAT_W-1:0]  w_mask;
  logic              w_match;

  // Handshake, next history and match decode. in_ready depends only on state
  // and the bit counter, never on in_valid.
  always_comb begin
    w_shift     = (r_state == ST_SHIFT);
    w_last      = w_shift && (r_bitcnt == BC_W'(WORD_W - 1));
    w_ready     = (r_state == ST_IDLE) || w_last;
    w_accept    = in_valid && w_ready;
    w_bit       = r_shreg[WORD_W-1];
    // The new bit enters at bit 0 and the oldest bit falls off the top.
    w_hist_next = PAT_W'({r_hist, w_bit});
    w_fill_next = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
    // The mask selects the low r_len bits. When r_len == PAT_W, the shift
    // moves every one out, so the mask covers the whole history.
    w_mask      = ~({PAT_W{1'b1}} << r_len);
    w_match     = w_shift && !cfg_clear && (r_len != '0) &&
                  (int'(w_fill_next) >= int'(r_len)) &&
                  (((w_hist_next ^ r_pat) & w_mask) == '0);
  end

  // Sequencer: IDLE waits for a word. SHIFT emits one bit per cycle and can
  // reload on its last cycle, so held in_valid gives gapless words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= '0;
      r_shreg  <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_shreg  <= in_data;
        r_bitcnt <= '0;
        r_state  <= ST_SHIFT;
      end
    end else begin
      if (w_last) begin
        r_bitcnt <= '0;
        if (in_valid) begin
          r_shreg <= in_data;
        end else begin
          r_shreg <= r_shreg << 1;
          r_state <= ST_IDLE;
        end
      end else begin
        r_shreg  <= r_shreg << 1;
        r_bitcnt <= r_bitcnt + BC_W'(1);
      end
    end
  end

  // Detector history and fill level. cfg_clear takes priority over the
  // shift, so the bit shifted on that edge is discarded.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (cfg_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_shift) begin
      r_hist <= w_hist_next;
      r_fill <= w_fill_next;
    end
  end

  // Pattern configuration. It can change only between words. A write
  // during SHIFT is dropped and is not queued.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pat <= '0;
      r_len <= '0;
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
    end
  end

  // Registered match pulse. It is high for the cycle after the edge that
  // shifted in the completing bit.
  always_ff @(posedge clk) begin
    if (!reset) r_pulse <= 1'b0;
    else        r_pulse <= w_match;
  end

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] r_count;

  // Saturating match counter. It updates on the same edge as the pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (cfg_clear) begin
      r_count <= '0;
    end else if (w_match && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign match_count = r_count;
`else
  assign match_count = '0;
`endif

  assign in_ready    = w_ready;
  assign match_pulse = r_pulse;
  assign busy        = (r_state == ST_SHIFT);
  assign state       = r_state;

endmodule

// File: tb/tb_serial_match_ctrl.sv
// tb_serial_match_ctrl
//   Directed scenarios followed by randomized traffic. Each cycle's result is
//   compared with a queue-based reference model: pending bits of the word in
//   flight, plus the last PAT_W received bits.
module tb_serial_match_ctrl;
  localparam int WORD_W = 8;
  localparam int PAT_W  = 6;
  localparam int CNT_W  = 8;
  localparam int LEN_W  = $clog2(PAT_W) + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we, cfg_clear, in_valid;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic [WORD_W-1:0] in_data;
  logic              in_ready, match_pulse, busy, state;
  logic [CNT_W-1:0]  match_count;

  serial_match_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_clear(cfg_clear), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .match_pulse(match_pulse),
    .match_count(match_count), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit               pend[$];
  bit               hist[$];
  logic [PAT_W-1:0] m_pat = '0;
  int               m_len = 0;
  int               m_cnt = 0;
  bit               m_pulse = 0;
  bit               last_acc = 0;

  int nvec = 0, nerr = 0;
  int pulses_seen = 0;
  int first_pulse;
  int nacc, guard;

  function automatic int mc(input int n);
`ifdef MATCH_COUNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply the current inputs for one clock. Advance the model and compare.
  task automatic step();
    bit rdy, shifting, b, acc, ok;
    rdy = (pend.size() <= 1);
    chk("in_ready", in_ready, rdy);
    @(posedge clk);
    if (!rst_n) begin
      pend.delete(); hist.delete();
      m_pat = '0; m_len = 0; m_cnt = 0; m_pulse = 0; last_acc = 0;
    end else begin
      acc      = in_valid && rdy;
      shifting = (pend.size() > 0);
      b        = 0;
      m_pulse  = 0;
      if (shifting) b = pend.pop_front();
      if (acc) for (int i = WORD_W-1; i >= 0; i--) pend.push_back(in_data[i]);
      if (cfg_we && !shifting) begin m_pat = cfg_pattern; m_len = int'(cfg_len); end
      if (cfg_clear) begin
        hist.delete(); m_cnt = 0;
      end else if (shifting) begin
        hist.push_back(b);
        if (hist.size() > PAT_W) void'(hist.pop_front());
        if (m_len != 0 && hist.size() >= m_len) begin
          ok = 1;
          for (int k = 0; k < m_len; k++)
            if (hist[hist.size()-1-k] != m_pat[k]) ok = 0;
          if (ok) begin
            m_pulse = 1;
            if (m_cnt < CMAX) m_cnt++;
          end
        end
      end
      last_acc = acc;
    end
    @(negedge clk);
    chk("match_pulse", match_pulse, m_pulse);
    chk("match_count", match_count, mc(m_cnt));
    chk("busy", busy, pend.size() > 0);
    chk("state", state, pend.size() > 0);
    if (match_pulse === 1'b1) pulses_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input int l);
    cfg_we = 1'b1; cfg_pattern = p; cfg_len = LEN_W'(l); step(); cfg_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 0; cfg_clear = 0; in_valid = 0;
    cfg_pattern = '0; cfg_len = '0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Check the values left by reset.
    chk("rst_state", state, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_count", match_count, 0);

    // Scenario 1: pattern 101011, len 6, word AC gives one match after bit 5.
    do_reset(); do_cfg(6'b101011, 6);
    pulses_seen = 0; first_pulse = -1;
    in_valid = 1; in_data = 8'hAC; step(); in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (match_pulse === 1'b1 && first_pulse < 0) first_pulse = i;
    end
    chk("s1_npulse", pulses_seen, 1);
    chk("s1_when", first_pulse, 6);
    chk("s1_count", match_count, mc(1));

    // Scenario 2: pattern 101, len 3, word AA gives overlapping matches.
    do_reset(); do_cfg(6'b000101, 3);
    pulses_seen = 0; first_pulse = -1;
    in_valid = 1; in_data = 8'hAA; step(); in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (match_pulse === 1'b1 && first_pulse < 0) first_pulse = i;
    end
    chk("s2_npulse", pulses_seen, 3);
    chk("s2_first", first_pulse, 3);
    chk("s2_count", match_count, mc(3));

    // Scenario 3: words 0A and C0 back-to-back give one match spanning both words.
    do_reset(); do_cfg(6'b101011, 6);
    pulses_seen = 0; first_pulse = -1;
    in_valid = 1; in_data = 8'h0A; step(); in_data = 8'hC0;
    repeat (6) step();
    chk("s3_ready_mid", in_ready, 0);
    step();
    chk("s3_ready_last", in_ready, 1);
    step();
    in_valid = 0;
    chk("s3_gapless", busy, 1);
    for (int i = 9; i <= 20; i++) begin
      step();
      if (match_pulse === 1'b1 && first_pulse < 0) first_pulse = i;
    end
    chk("s3_npulse", pulses_seen, 1);
    chk("s3_when", first_pulse, 10);
    chk("s3_count", match_count, mc(1));

    // Scenario 4: pattern 1, len 1, 32 FF words; the counter saturates.
    do_reset(); do_cfg(6'b000001, 1);
    pulses_seen = 0; nacc = 0; guard = 0;
    in_valid = 1; in_data = 8'hFF;
    while (nacc < 32 && guard < 400) begin
      step(); guard++;
      if (last_acc) nacc++;
    end
    in_valid = 0;
    chk("s4_accepted", nacc, 32);
    repeat (12) step();
    chk("s4_npulse", pulses_seen, 256);
    chk("s4_count", match_count, mc(255));

    // Scenario 5: reset during bit 3, then a config write during SHIFT is ignored.
    do_reset(); do_cfg(6'b000001, 1);
    in_valid = 1; in_data = 8'hFF; step(); in_valid = 0;
    repeat (3) step();
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("s5_state", state, 0);
    chk("s5_ready", in_ready, 1);
    chk("s5_pulse", match_pulse, 0);
    chk("s5_count", match_count, 0);
    do_cfg(6'b000001, 1);
    pulses_seen = 0;
    in_valid = 1; in_data = 8'hFF; step(); in_valid = 0;
    step();
    do_cfg(6'b000000, 1);
    repeat (10) step();
    chk("s5_oldpat", pulses_seen, 8);

    // Randomized traffic with occasional config writes, clears and resets.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = WORD_W'($urandom);
      cfg_we      = ($urandom_range(0, 14) == 0);
      cfg_pattern = PAT_W'($urandom);
      cfg_len     = LEN_W'($urandom_range(0, PAT_W));
      cfg_clear   = ($urandom_range(0, 39) == 0);
      step();
    end
    rst_n = 1'b1; in_valid = 0; cfg_we = 0; cfg_clear = 0;
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
